// File: rtl/comparator_bist.sv
// Self-test engine for a WIDTH-bit comparator: sweeps every {A,B} pair, holds each
// for SETTLE+1 cycles, samples Y and checks it against the selected compare function.
module comparator_bist #(
    parameter int WIDTH  = 1,
    parameter int MODE   = 0,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic               Y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [2*WIDTH-1:0] fail_vec,
    output logic               fail_valid
);

    localparam int VW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // With no settle time a vector goes straight to CHECK so it is held exactly one cycle.
    localparam logic [1:0]    FIRST_STATE = (SETTLE == 0) ? S_CHECK : S_DRIVE;
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [VW-1:0] V_LAST      = '1;

    logic [1:0]    state_q, state_d;
    logic [VW-1:0] v_q, v_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [VW:0]   err_q, err_d;
    logic [VW-1:0] fv_q, fv_d;
    logic          fvv_q, fvv_d;
    logic          pass_q, pass_d;

    logic [WIDTH-1:0] a_w, b_w;
    logic             exp_y;
    logic             mismatch;

    assign a_w = v_q[VW-1:WIDTH];
    assign b_w = v_q[WIDTH-1:0];

    always_comb begin
        case (MODE)
            1:       exp_y = (a_w > b_w);
            2:       exp_y = (a_w < b_w);
            default: exp_y = (a_w == b_w);
        endcase
    end

    assign mismatch = (state_q == S_CHECK) && (Y != exp_y);

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvv_d   = fvv_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = '0;
                    fv_d    = '0;
                    fvv_d   = 1'b0;
                    pass_d  = 1'b0;
                    v_d     = '0;
                    cnt_d   = '0;
                    state_d = FIRST_STATE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + (VW + 1)'(1);
                    if (!fvv_q) begin
                        fv_d  = v_q;
                        fvv_d = 1'b1;
                    end
                end
                cnt_d = '0;
                if (v_q == V_LAST) begin
                    // err_d already holds this final vector's outcome.
                    pass_d  = (err_d == '0);
                    v_d     = '0;
                    state_d = S_FINISH;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = FIRST_STATE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= '0;
            fvv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvv_q   <= fvv_d;
            pass_q  <= pass_d;
        end
    end

    assign A          = a_w;
    assign B          = b_w;
    assign busy       = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign done       = (state_q == S_FINISH);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_vec   = fv_q;
    assign fail_valid = fvv_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (1-bit equality, 2-bit greater-than) driven
// by ideal or faulty comparator models, checked against a sweep-level reference model.
module tb_comparator_bist;

    logic       clk, rst;
    logic       start1, start2;
    logic [0:0] A1, B1;
    logic       Y1, busy1, done1, pass1, fvv1;
    logic [2:0] err1;
    logic [1:0] fv1;
    logic [1:0] A2, B2;
    logic       Y2, busy2, done2, pass2, fvv2;
    logic [4:0] err2;
    logic [3:0] fv2;

    int fault1, fault2, sel;
    int n_vec, n_err;

    logic        m_busy, m_done, m_pass, m_fvv;
    logic [31:0] m_ab, m_err, m_fv;

    comparator_bist #(.WIDTH(1), .MODE(0), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Y(Y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fv1), .fail_valid(fvv1)
    );

    comparator_bist #(.WIDTH(2), .MODE(1), .SETTLE(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2), .Y(Y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_vec(fv2), .fail_valid(fvv2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit golden(input int mode, input int a, input int b);
        case (mode)
            1:       return a > b;
            2:       return a < b;
            default: return a == b;
        endcase
    endfunction

    // Device models: instance 0 is an XNOR or stuck-at-0; instance 1 is A>B with a hole at (3,1).
    function automatic bit dev_y(input int which, input int fault, input int a, input int b);
        if (which == 0) return (fault != 0) ? 1'b0 : golden(0, a, b);
        if (fault != 0 && a == 3 && b == 1) return 1'b0;
        return golden(1, a, b);
    endfunction

    always_comb Y1 = dev_y(0, fault1, int'(A1), int'(B1));
    always_comb Y2 = dev_y(1, fault2, int'(A2), int'(B2));

    always_comb begin
        if (sel == 0) begin
            m_busy = busy1; m_done = done1; m_pass = pass1; m_fvv = fvv1;
            m_ab = 32'({A1, B1}); m_err = 32'(err1); m_fv = 32'(fv1);
        end else begin
            m_busy = busy2; m_done = done2; m_pass = pass2; m_fvv = fvv2;
            m_ab = 32'({A2, B2}); m_err = 32'(err2); m_fv = 32'(fv2);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start1 = v; else start2 = v;
    endtask

    task automatic run_test(input int s, input int fault, input bit pulse_mid);
        int w, st, mode, n, exp_err, exp_first, done_cnt, lim;
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        logic [31:0] got_pass, got_err, got_fv, got_fvv, got_ab;
        sel  = s;
        w    = (s == 0) ? 1 : 2;
        st   = (s == 0) ? 1 : 0;
        mode = (s == 0) ? 0 : 1;
        n    = 1 << (2 * w);
        if (s == 0) fault1 = fault; else fault2 = fault;
        exp_err   = 0;
        exp_first = -1;
        for (int v = 0; v < n; v++) begin
            int a, b;
            a = v >> w;
            b = v & ((1 << w) - 1);
            for (int k = 0; k <= st; k++) exp_q.push_back(32'(v));
            if (dev_y(s, fault, a, b) != golden(mode, a, b)) begin
                exp_err++;
                if (exp_first < 0) exp_first = v;
            end
        end
        got_pass = '1; got_err = '1; got_fv = '1; got_fvv = '1; got_ab = '1;
        @(negedge clk); set_start(s, 1'b1);
        @(negedge clk); set_start(s, 1'b0);
        check_eq("clear_err", m_err, 0);
        check_eq("clear_fail_valid", 32'(m_fvv), 0);
        check_eq("clear_pass", 32'(m_pass), 0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (pulse_mid && c == 3) set_start(s, 1'b1);
            if (pulse_mid && c == 4) set_start(s, 1'b0);
            if (m_busy) obs_q.push_back(m_ab);
            if (m_done) begin
                done_cnt++;
                got_pass = 32'(m_pass); got_err = m_err; got_fv = m_fv;
                got_fvv = 32'(m_fvv); got_ab = m_ab;
            end
        end
        check_eq("busy_cycles", obs_q.size(), exp_q.size());
        lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check_eq($sformatf("ab_seq[%0d]", i), obs_q[i], exp_q[i]);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("pass", got_pass, (exp_err == 0) ? 1 : 0);
        check_eq("err_count", got_err, exp_err);
        check_eq("fail_vec", got_fv, (exp_first < 0) ? 0 : exp_first);
        check_eq("fail_valid", got_fvv, (exp_first < 0) ? 0 : 1);
        check_eq("ab_at_done", got_ab, 0);
        check_eq("hold_pass", 32'(m_pass), (exp_err == 0) ? 1 : 0);
        check_eq("hold_err", m_err, exp_err);
        check_eq("hold_fail_vec", m_fv, (exp_first < 0) ? 0 : exp_first);
        check_eq("idle_busy", 32'(m_busy), 0);
    endtask

    task automatic reset_mid_run();
        int found;
        sel    = 0;
        fault1 = 1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (m_ab == 32'd2) found = 1;
            else @(negedge clk);
        end
        check_eq("reach_vec2", found, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy1), 0);
        check_eq("arst_ab", m_ab, 0);
        check_eq("arst_err", 32'(err1), 0);
        check_eq("arst_fail_valid", 32'(fvv1), 0);
        check_eq("arst_fail_vec", 32'(fv1), 0);
        check_eq("arst_pass", 32'(pass1), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("arst_no_done", 32'(done1), 0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("post_rst_no_done", 32'(done1), 0);
            check_eq("post_rst_idle", 32'(busy1), 0);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        sel    = 0;
        fault1 = 0;
        fault2 = 0;
        start1 = 1'b0;
        start2 = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy1", 32'(busy1), 0);
        check_eq("rst_done1", 32'(done1), 0);
        check_eq("rst_ab1", 32'({A1, B1}), 0);
        check_eq("rst_err1", 32'(err1), 0);
        check_eq("rst_pass1", 32'(pass1), 0);
        check_eq("rst_fvv1", 32'(fvv1), 0);
        check_eq("rst_busy2", 32'(busy2), 0);
        check_eq("rst_ab2", 32'({A2, B2}), 0);
        check_eq("rst_err2", 32'(err2), 0);
        check_eq("rst_fv2", 32'(fv2), 0);

        run_test(0, 0, 1'b0);
        run_test(0, 1, 1'b0);
        run_test(0, 0, 1'b0);
        run_test(1, 1, 1'b0);
        run_test(1, 0, 1'b1);
        run_test(0, 1, 1'b1);
        reset_mid_run();
        run_test(0, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int s;
            s = int'($urandom_range(1, 0));
            run_test(s, int'($urandom_range(1, 0)), 1'(($urandom_range(1, 0))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
- Built-in self-test engine that sits on the driving side of a comparator instance.
- Generates every A/B input combination in order, holds each for a settle window, and samples the comparator's Y.
- Checks Y against a golden reference and reports pass/fail, error count and first failing vector.
- Lets a comparator be signed off on silicon/FPGA without a simulation bench.

Parameters:
- WIDTH, 1, bit width of each comparator operand A and B.
- MODE, 0, comparator function under test: 0 = equality (A==B), 1 = greater (A>B), 2 = less (A<B); 3 is treated as 0.
- SETTLE, 1, extra cycles each vector is held before Y is sampled; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a test run; sampled only in IDLE
- A  output  WIDTH  operand A driven to the comparator
- B  output  WIDTH  operand B driven to the comparator
- Y  input  1  comparator result under test
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at end of run
- pass  output  1  run result, valid from done until next start
- err_count  output  2*WIDTH+1  number of mismatching vectors in the last run
- fail_vec  output  2*WIDTH  {A,B} of the first mismatching vector
- fail_valid  output  1  fail_vec holds a captured vector

Behaviour:
- Reset (asynchronous, any time, including mid-run): state IDLE; A=0, B=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0; settle and vector counters cleared.
- States: IDLE, DRIVE, CHECK, FINISH.
- IDLE:
  - start=1 clears err_count, fail_vec, fail_valid and pass.
  - Loads vector index v=0, drives {A,B}=0, sets busy=1, goes to DRIVE.
  - start=0: stay in IDLE.
- Vector ordering:
  - v counts 0 .. 2^(2*WIDTH)-1.
  - A=v[2*WIDTH-1:WIDTH] (major), B=v[WIDTH-1:0] (minor).
  - WIDTH=1 order: (0,0),(0,1),(1,0),(1,1).
- DRIVE:
  - Hold A/B for SETTLE cycles, counted by the settle counter, then go to CHECK.
  - SETTLE=0 goes to CHECK on the next edge.
- CHECK (one cycle):
  - Sample Y on the edge leaving CHECK and compare to expected, computed unsigned from the registered A/B.
  - On mismatch: err_count+1 (cannot overflow at this width).
  - On the first mismatch of the run only: fail_vec={A,B} and fail_valid=1.
  - If v is not last: v+1, drive the new A/B, go to DRIVE.
  - Else go to FINISH.
- Timing: each vector is presented for exactly SETTLE+1 cycles; busy is high for 2^(2*WIDTH)*(SETTLE+1) cycles.
- FINISH (one cycle):
  - busy=0, done=1, pass=(err_count==0); A/B return to 0; go to IDLE.
  - The final CHECK's error is already included in err_count and pass.
- start while busy=1 is ignored; start held high through FINISH launches a new run from the IDLE cycle that follows.
- Results:
  - pass, err_count, fail_vec and fail_valid hold after FINISH until the next accepted start.
  - They are cleared on the cycle start is accepted.
- Y is assumed combinationally stable within SETTLE+1 cycles; no synchronizer is inserted.

Test Plan:
- WIDTH=1, MODE=0, SETTLE=1, ideal XNOR comparator model; pulse start -> busy high 8 cycles; A/B sequence 00,01,10,11 with 2 cycles each; done pulse 1 cycle; pass=1; err_count=0; fail_valid=0.
- Same configuration, Y stuck at 0 -> err_count=2 (vectors 00 and 11); fail_vec=2'b00; fail_valid=1; pass=0.
- WIDTH=2, MODE=1, SETTLE=0, model returns A>B except forced 0 at A=3,B=1 -> busy for 16 cycles; err_count=1; fail_vec=4'b1101; pass=0.
- Assert rst during vector 2 of a WIDTH=1 run -> outputs zero immediately (asynchronous); no done pulse; subsequent start runs a clean full sequence with pass=1.
- Pulse start again while busy -> ignored; run length unchanged; exactly one done pulse.
- Back-to-back runs, with the first failing and the second using a fixed model -> second start clears err_count and fail_valid; final pass=1, err_count=0.
